// File: rtl/cap_sense_scanner_if.sv
// cap_sense_scanner_if
// Processor-side view of the capacitive pad scanner: the touched vector,
// scan status and the indexed count readback port.
// master = processor I/O decode, slave = scanner.
interface cap_sense_scanner_if #(
  parameter int NUM_SENSORS = 9
);
  logic [NUM_SENSORS-1:0] touched;
  logic                   scan_done;
  logic                   busy;
  logic [3:0]             count_sel;
  logic [15:0]            count_data;

  modport master (
    input  touched,
    input  scan_done,
    input  busy,
    input  count_data,
    output count_sel
  );

  modport slave (
    output touched,
    output scan_done,
    output busy,
    output count_data,
    input  count_sel
  );
endinterface

// File: rtl/cap_sense_scanner.sv
// cap_sense_scanner
// Runs the shared charge line through discharge/charge phases and times
// when each synchronized pad input rises. Rise times become per-sensor
// counts and a touched vector, published together once per scan.
// Optional build macro: CAP_SENSE_DEBOUNCE_EN. When it is defined, a touched
// bit only changes once the raw result agrees across two consecutive scans.
module cap_sense_scanner #(
  parameter int NUM_SENSORS      = 9,
  parameter int DISCHARGE_CYCLES = 256,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int THRESHOLD        = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  cap_sense_scanner_if.slave     host
);

  localparam int              DW          = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [DW-1:0]   DIS_LAST    = DW'(DISCHARGE_CYCLES - 1);
  localparam logic [15:0]     CHARGE_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0]     THRESH_VAL  = 16'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCHARGE,
    S_CHARGE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [DW-1:0]          r_dis_cnt;
  logic [15:0]            r_charge_cnt;
  logic [NUM_SENSORS-1:0] r_latched;
  logic [15:0]            r_count     [NUM_SENSORS];
  logic [15:0]            r_count_out [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_touched;
  logic                   r_scan_done;
  logic                   r_busy;
  logic                   r_out;
  logic [NUM_SENSORS-1:0] r_sync1;
  logic [NUM_SENSORS-1:0] r_sync2;
`ifdef CAP_SENSE_DEBOUNCE_EN
  logic [NUM_SENSORS-1:0] r_prev_raw;
`endif

  logic [NUM_SENSORS-1:0] w_latch_now;
  logic [NUM_SENSORS-1:0] w_touched_raw;
  logic                   w_all_latched;
  logic                   w_timeout;
  logic                   w_charge_exit;
  logic [15:0]            w_count_data;

  // Two-flop synchronizer on every raw pad input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= capacitive_sensors_in;
      r_sync2 <= r_sync1;
    end
  end

  // A sensor latches on the first charge cycle its synchronized input is high;
  // the phase ends once everyone has latched or the timeout cycle is reached.
  assign w_latch_now   = r_sync2 & ~r_latched;
  assign w_all_latched = &(r_latched | w_latch_now);
  assign w_timeout     = (r_charge_cnt == CHARGE_LAST);
  assign w_charge_exit = w_all_latched | w_timeout;

  // Threshold compare on the counts latched during the scan just finished.
  always_comb begin
    w_touched_raw = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_touched_raw[i] = (r_count[i] >= THRESH_VAL);
    end
  end

  // Scan sequencer: discharge, charge/time, evaluate, publish results.
  // NOTE: the per-sensor count arrays are reset explicitly; they are a few
  // flops each, not a RAM, and readback must show 0 straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_dis_cnt    <= '0;
      r_charge_cnt <= '0;
      r_latched    <= '0;
      r_touched    <= '0;
      r_scan_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_out        <= 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_count[i]     <= '0;
        r_count_out[i] <= '0;
      end
`ifdef CAP_SENSE_DEBOUNCE_EN
      r_prev_raw   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out       <= 1'b0;
          r_scan_done <= 1'b0;
          if (enable) begin
            r_state   <= S_DISCHARGE;
            r_busy    <= 1'b1;
            r_dis_cnt <= '0;
          end
        end

        S_DISCHARGE: begin
          if (r_dis_cnt == DIS_LAST) begin
            r_state      <= S_CHARGE;
            r_out        <= 1'b1;
            r_charge_cnt <= '0;
            r_latched    <= '0;
          end else begin
            r_dis_cnt <= r_dis_cnt + 1'b1;
          end
        end

        S_CHARGE: begin
          r_latched <= r_latched | w_latch_now;
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (w_latch_now[i]) begin
              r_count[i] <= r_charge_cnt;
            end else if (!r_latched[i] && w_charge_exit) begin
              r_count[i] <= TIMEOUT_VAL;
            end
          end
          if (w_charge_exit) begin
            r_state <= S_EVAL;
            r_out   <= 1'b0;
          end else begin
            r_charge_cnt <= r_charge_cnt + 1'b1;
          end
        end

        S_EVAL: begin
          r_state     <= S_DONE;
          r_scan_done <= 1'b1;
          for (int i = 0; i < NUM_SENSORS; i++) begin
            r_count_out[i] <= r_count[i];
          end
`ifdef CAP_SENSE_DEBOUNCE_EN
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (w_touched_raw[i] == r_prev_raw[i]) begin
              r_touched[i] <= w_touched_raw[i];
            end
          end
          r_prev_raw <= w_touched_raw;
`else
          r_touched <= w_touched_raw;
`endif
        end

        S_DONE: begin
          r_scan_done <= 1'b0;
          if (enable) begin
            r_state   <= S_DISCHARGE;
            r_dis_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_out       <= 1'b0;
          r_scan_done <= 1'b0;
        end
      endcase
    end
  end

  // Count readback mux; indices past the last sensor read as zero.
  // NOTE: the default assignment up front keeps this purely combinational;
  // without it, an unmatched index would hold the old value and infer a latch.
  always_comb begin
    w_count_data = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (host.count_sel == 4'(i)) begin
        w_count_data = r_count_out[i];
      end
    end
  end

  assign capacitive_sensors_out = r_out;
  assign host.touched           = r_touched;
  assign host.scan_done         = r_scan_done;
  assign host.busy              = r_busy;
  assign host.count_data        = w_count_data;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// tb_cap_sense_scanner
// Directed scans with hand-computed counts, touched vectors and scan
// lengths pushed to a scoreboard; a monitor pops and compares on scan_done.
// Expected touched values follow CAP_SENSE_DEBOUNCE_EN when it is defined.
module tb_cap_sense_scanner;

  localparam int N   = 9;
  localparam int DIS = 4;
  localparam int TO  = 64;
  localparam int TH  = 20;

  typedef int vec_t [N];

  typedef struct {
    logic [N-1:0] touched;
    vec_t         counts;
    int           len;
  } exp_t;

  logic         clock  = 1'b0;
  logic         reset  = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] pads   = '0;
  logic         cs_out;

  exp_t sb_q [$];
  exp_t mon_e;
  int   checks      = 0;
  int   failures    = 0;
  int   done_pulses = 0;
  int   mon_cyc     = 0;

  cap_sense_scanner_if #(.NUM_SENSORS(N)) bus ();

  cap_sense_scanner #(
    .NUM_SENSORS      (N),
    .DISCHARGE_CYCLES (DIS),
    .TIMEOUT_CYCLES   (TO),
    .THRESHOLD        (TH)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .capacitive_sensors_in  (pads),
    .capacitive_sensors_out (cs_out),
    .host                   (bus)
  );

  always #20 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every scan_done pops one expected scan and compares touched,
  // scan length (DISCHARGE entry = cycle 1) and all 16 readback indices.
  initial begin : monitor
    bus.count_sel = 4'd3;
    forever begin
      @(negedge clock);
      if (bus.busy !== 1'b1) mon_cyc = 0;
      else mon_cyc++;
      if (bus.scan_done === 1'b1) begin
        done_pulses++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_scan_done actual=1 expected=0");
        end else begin
          mon_e = sb_q.pop_front();
          check("touched", 32'(bus.touched), 32'(mon_e.touched));
          check("scan_len", 32'(mon_cyc), 32'(mon_e.len));
          for (int s = 0; s < 16; s++) begin
            bus.count_sel = 4'(s);
            #1;
            if (s < N) check($sformatf("count[%0d]", s), 32'(bus.count_data), 32'(mon_e.counts[s]));
            else       check($sformatf("count[%0d]", s), 32'(bus.count_data), 32'd0);
          end
          bus.count_sel = 4'd3;
        end
        mon_cyc = 0;
      end
    end
  end

  // Wait (bounded) for the charge line to be high at a falling edge.
  task automatic wait_charge(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (cs_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL charge_timeout actual=0 expected=1");
    end
  endtask

  // Drive one scan: rise[i] is the charge cycle before whose ending edge pad i
  // goes high (-1 = never). drop_at >= 0 deasserts enable at that cycle.
  task automatic run_scan(input vec_t rise, input vec_t exp_counts, input logic [N-1:0] exp_touched,
                          input int exp_len, input int drop_at);
    exp_t e;
    bit   ok;
    int   c;
    e.touched = exp_touched;
    e.counts  = exp_counts;
    e.len     = exp_len;
    sb_q.push_back(e);
    pads = '0;
    wait_charge(ok);
    if (ok) begin
      c = 0;
      while (cs_out === 1'b1 && c < TO + 10) begin
        for (int i = 0; i < N; i++) if (rise[i] == c) pads[i] = 1'b1;
        if (c == drop_at) enable = 1'b0;
        @(negedge clock);
        c++;
      end
    end
    pads = '0;
  endtask

  // Bounded wait for the FSM to return to IDLE.
  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (bus.busy === 1'b0) break;
    end
    check("idle_reached_busy", 32'(bus.busy), 32'd0);
  endtask

  vec_t rise_all5  = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
  vec_t rise_p3_30 = '{5, 5, 5, 30, 5, 5, 5, 5, 5};
  vec_t rise_p8_nv = '{5, 5, 5, 5, 5, 5, 5, 5, -1};
  vec_t cnt_all7   = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
  vec_t cnt_p3_32  = '{7, 7, 7, 32, 7, 7, 7, 7, 7};
  vec_t cnt_p8_64  = '{7, 7, 7, 7, 7, 7, 7, 7, 64};

`ifdef CAP_SENSE_DEBOUNCE_EN
  logic [N-1:0] t_a = 9'h000, t_b = 9'h000, t_c = 9'h000, t_d = 9'h000, t_e = 9'h008, t_f = 9'h008;
`else
  logic [N-1:0] t_a = 9'h000, t_b = 9'h008, t_c = 9'h100, t_d = 9'h008, t_e = 9'h008, t_f = 9'h000;
`endif

  bit ok_main;

  initial begin : stimulus
    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_out", 32'(cs_out), 32'd0);
    check("rst_touched", 32'(bus.touched), 32'd0);
    check("rst_scan_done", 32'(bus.scan_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count_data", 32'(bus.count_data), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_no_enable_busy", 32'(bus.busy), 32'd0);

    // Back-to-back scans with enable held high.
    enable = 1'b1;
    run_scan(rise_all5,  cnt_all7,  t_a, 14, -1);
    run_scan(rise_p3_30, cnt_p3_32, t_b, 39, -1);
    run_scan(rise_p8_nv, cnt_p8_64, t_c, 70, -1);
    run_scan(rise_p3_30, cnt_p3_32, t_d, 39, -1);
    run_scan(rise_p3_30, cnt_p3_32, t_e, 39, -1);
    // Enable dropped mid-CHARGE: scan completes, then IDLE.
    run_scan(rise_all5,  cnt_all7,  t_f, 14, 2);
    wait_idle();
    repeat (20) @(negedge clock);
    check("after_drop_busy", 32'(bus.busy), 32'd0);
    check("after_drop_out", 32'(cs_out), 32'd0);
    check("after_drop_pulses", 32'(done_pulses), 32'd6);

    // Reset asserted mid-CHARGE takes effect without a clock edge.
    enable = 1'b1;
    wait_charge(ok_main);
    repeat (3) @(negedge clock);
    check("pre_rst_out", 32'(cs_out), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_out", 32'(cs_out), 32'd0);
    check("midrst_touched", 32'(bus.touched), 32'd0);
    check("midrst_scan_done", 32'(bus.scan_done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_count_data", 32'(bus.count_data), 32'd0);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    check("post_rst_idle_out", 32'(cs_out), 32'd0);

    // One more scan after reset; debounce history was cleared too.
    enable = 1'b1;
    run_scan(rise_all5, cnt_all7, 9'h000, 14, 2);
    wait_idle();
    repeat (5) @(negedge clock);
    check("final_pulses", 32'(done_pulses), 32'd7);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
